tx: RTL and testbench

- Tag backscatter transmitter for EPC Class 1 Gen 2; the reverse-link counterpart of the PIE receiver.
- Takes a serial bit stream from the command/response logic and produces the modulator drive signal `txout`.
- Encoding is FM0 or Miller (M = 2/4/8), with preamble, optional TRext pilot and a trailing dummy-1.
- Link timing is derived from the receiver's TRcal measurement, using DR = 8.

---
 rtl/tx.sv | 215 +++++++++++++++++++++
 tb/tb_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tx.sv
// EPC Gen2 backscatter transmitter: FM0 / Miller encoder with pilot, preamble and dummy-1.
// Half-BLF period is taken from the receiver's TRcal count (DR = 8, HP = TRcal/16).
module tx #(
   parameter int HPSHIFT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] trcal,
   input  logic [1:0] m,
   input  logic       trext,
   input  logic       start,
   input  logic       txbit,
   input  logic       txlast,
   output logic       txout,
   output logic       bitreq,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, PILOT, PREAMBLE, DATA, DUMMY, DONE} state_t;

   // Preamble symbol values, symbol i in bit i (FM0 symbol 4 is the violation V)
   localparam logic [7:0] FM0_PRE = 8'b0010_0101;
   localparam logic [7:0] MIL_PRE = 8'b0011_1010;

   state_t     state_reg, state_next;
   logic [9:0] hp_reg, hp_next;
   logic [9:0] cnt_reg, cnt_next;
   logic [1:0] m_reg, m_next;
   logic       trext_reg, trext_next;
   logic [3:0] hidx_reg, hidx_next;
   logic [4:0] idx_reg, idx_next;
   logic       bit_reg, bit_next;
   logic       v_reg, v_next;
   logic       last_reg, last_next;
   logic       lvl_reg, lvl_next;
   logic       bb_reg, bb_next;
   logic       prev_reg, prev_next;
   logic       sc_reg, sc_next;

   logic [9:0] hp_shift, hp_calc;
   logic       is_fm0, half_end, sym_end, in_frame;
   logic [3:0] nhalf_m1, mid_idx;
   logic [4:0] pilot_last;
   logic [7:0] pre_bits;
   logic [2:0] pre_nidx;
   logic       load, ld_bit, ld_v, lvl_base, bb_base, prev_base;

   assign hp_shift   = trcal >> HPSHIFT;
   assign hp_calc    = (hp_shift == 10'd0) ? 10'd1 : hp_shift;
   assign is_fm0     = (m_reg == 2'd0);
   // Symbol length in half-periods is 2 for FM0 and 2M for Miller, i.e. 2 << m
   assign nhalf_m1   = 4'((5'd2 << m_reg) - 5'd1);
   assign mid_idx    = 4'(5'd1 << m_reg);
   assign half_end   = (cnt_reg == hp_reg - 10'd1);
   assign sym_end    = half_end && (hidx_reg == nhalf_m1);
   assign pilot_last = is_fm0 ? 5'd11 : (trext_reg ? 5'd15 : 5'd3);
   assign pre_bits   = is_fm0 ? FM0_PRE : MIL_PRE;
   assign pre_nidx   = idx_reg[2:0] + 3'd1;
   assign in_frame   = (state_reg == PILOT) || (state_reg == PREAMBLE) ||
                       (state_reg == DATA)  || (state_reg == DUMMY);

   assign busy   = in_frame;
   assign done   = (state_reg == DONE);
   assign txout  = in_frame && (is_fm0 ? lvl_reg : (bb_reg ^ sc_reg));
   assign bitreq = sym_end && (((state_reg == PREAMBLE) && (idx_reg == 5'd5)) ||
                               ((state_reg == DATA) && !last_reg));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         hp_reg    <= 10'd1;
         cnt_reg   <= 10'd0;
         m_reg     <= 2'd0;
         trext_reg <= 1'b0;
         hidx_reg  <= 4'd0;
         idx_reg   <= 5'd0;
         bit_reg   <= 1'b0;
         v_reg     <= 1'b0;
         last_reg  <= 1'b0;
         lvl_reg   <= 1'b0;
         bb_reg    <= 1'b0;
         prev_reg  <= 1'b1;
         sc_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         hp_reg    <= hp_next;
         cnt_reg   <= cnt_next;
         m_reg     <= m_next;
         trext_reg <= trext_next;
         hidx_reg  <= hidx_next;
         idx_reg   <= idx_next;
         bit_reg   <= bit_next;
         v_reg     <= v_next;
         last_reg  <= last_next;
         lvl_reg   <= lvl_next;
         bb_reg    <= bb_next;
         prev_reg  <= prev_next;
         sc_reg    <= sc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      hp_next    = hp_reg;
      cnt_next   = cnt_reg;
      m_next     = m_reg;
      trext_next = trext_reg;
      hidx_next  = hidx_reg;
      idx_next   = idx_reg;
      bit_next   = bit_reg;
      v_next     = v_reg;
      last_next  = last_reg;
      lvl_next   = lvl_reg;
      bb_next    = bb_reg;
      prev_next  = prev_reg;
      sc_next    = sc_reg;
      load       = 1'b0;
      ld_bit     = 1'b0;
      ld_v       = 1'b0;
      lvl_base   = lvl_reg;
      bb_base    = bb_reg;
      prev_base  = prev_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               hp_next    = hp_calc;
               m_next     = m;
               trext_next = trext;
               cnt_next   = 10'd0;
               hidx_next  = 4'd0;
               idx_next   = 5'd0;
               sc_next    = 1'b0;
               last_next  = 1'b0;
               lvl_base   = 1'b0;
               bb_base    = 1'b0;
               prev_base  = 1'b1;
               load       = 1'b1;
               if ((m == 2'd0) && !trext) begin
                  state_next = PREAMBLE;
                  ld_bit     = FM0_PRE[0];
               end else begin
                  state_next = PILOT;
               end
            end
         end
         DONE: state_next = IDLE;
         default: begin
            cnt_next = cnt_reg + 10'd1;
            if (half_end) begin
               cnt_next  = 10'd0;
               sc_next   = ~sc_reg;
               hidx_next = hidx_reg + 4'd1;
               // Mid-symbol transitions
               if (hidx_reg + 4'd1 == mid_idx) begin
                  if (is_fm0) begin
                     if (!bit_reg || v_reg) lvl_next = ~lvl_reg;
                  end else if (bit_reg) begin
                     bb_next = ~bb_reg;
                  end
               end
               if (sym_end) begin
                  hidx_next = 4'd0;
                  case (state_reg)
                     PILOT: begin
                        load = 1'b1;
                        if (idx_reg == pilot_last) begin
                           state_next = PREAMBLE;
                           idx_next   = 5'd0;
                           ld_bit     = pre_bits[0];
                        end else begin
                           idx_next = idx_reg + 5'd1;
                        end
                     end
                     PREAMBLE: begin
                        load = 1'b1;
                        if (idx_reg == 5'd5) begin
                           state_next = DATA;
                           ld_bit     = txbit;
                           last_next  = txlast;
                        end else begin
                           idx_next = idx_reg + 5'd1;
                           ld_bit   = pre_bits[pre_nidx];
                           ld_v     = is_fm0 && (pre_nidx == 3'd4);
                        end
                     end
                     DATA: begin
                        load = 1'b1;
                        if (last_reg) begin
                           state_next = DUMMY;
                           ld_bit     = 1'b1;
                        end else begin
                           ld_bit    = txbit;
                           last_next = txlast;
                        end
                     end
                     default: state_next = DONE;
                  endcase
               end
            end
         end
      endcase

      // Symbol-start transitions; both encoders track so the mode can be latched at start
      if (load) begin
         bit_next  = ld_bit;
         v_next    = ld_v;
         prev_next = ld_bit;
         lvl_next  = ld_v ? lvl_base : ~lvl_base;
         bb_next   = (!ld_bit && !prev_base) ? ~bb_base : bb_base;
      end
   end

endmodule

// File: tb/tb_tx.sv
// Bench for tx: directed and randomized frames checked cycle by cycle against a
// symbol-level FM0/Miller reference waveform built from the encoding rules.
module tb_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] trcal;
   logic [1:0] m;
   logic       trext;
   logic       start;
   logic       txbit;
   logic       txlast;
   logic       txout;
   logic       bitreq;
   logic       busy;
   logic       done;

   int vectors = 0;
   int miscompares = 0;

   tx dut (
      .clk    (clk),
      .reset  (reset),
      .trcal  (trcal),
      .m      (m),
      .trext  (trext),
      .start  (start),
      .txbit  (txbit),
      .txlast (txlast),
      .txout  (txout),
      .bitreq (bitreq),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns just after a negedge.
   task automatic run_frame(input logic [1:0] fm, input logic ftx, input logic [9:0] ftr,
                            input logic [15:0] dbits, input int nbits, input bit glitch,
                            input int disturb_at, input int abort_at);
      int hp, mm, npil, len, k, nreq, err0;
      bit lvl, bb, pp, ss;
      bit sb[$];
      bit sv[$];
      bit lv[$];
      bit rq[$];
      hp = int'(ftr) / 16;
      if (hp < 1) hp = 1;
      mm   = (fm == 2'd0) ? 1 : (1 << fm);
      npil = (fm == 2'd0) ? (ftx ? 12 : 0) : (ftx ? 16 : 4);
      for (int i = 0; i < npil; i++) begin sb.push_back(1'b0); sv.push_back(1'b0); end
      for (int i = 0; i < 6; i++) begin
         if (fm == 2'd0) begin
            sb.push_back(i == 0 || i == 2 || i == 5);
            sv.push_back(i == 4);
         end else begin
            sb.push_back(i == 1 || i >= 3);
            sv.push_back(1'b0);
         end
      end
      for (int i = 0; i < nbits; i++) begin sb.push_back(dbits[i]); sv.push_back(1'b0); end
      sb.push_back(1'b1);
      sv.push_back(1'b0);

      lvl = 1'b0; bb = 1'b0; pp = 1'b1; ss = 1'b0;
      foreach (sb[s]) begin
         bit want_req;
         want_req = (s == npil + 5) || (s >= npil + 6 && s < npil + 5 + nbits);
         if (fm == 2'd0) begin
            if (!sv[s]) lvl = ~lvl;
         end else begin
            if (!sb[s] && !pp) bb = ~bb;
            pp = sb[s];
         end
         for (int h = 0; h < 2 * mm; h++) begin
            if (h == mm) begin
               if (fm == 2'd0) begin
                  if (!sb[s] || sv[s]) lvl = ~lvl;
               end else if (sb[s]) begin
                  bb = ~bb;
               end
            end
            for (int c = 0; c < hp; c++) begin
               lv.push_back((fm == 2'd0) ? lvl : (bb ^ ss));
               rq.push_back(want_req && (h == 2 * mm - 1) && (c == hp - 1));
            end
            ss = ~ss;
         end
      end
      len = lv.size();

      m = fm; trext = ftx; trcal = ftr;
      txbit = dbits[0]; txlast = (nbits == 1);
      start = 1'b1;
      k = 0; nreq = 0; err0 = miscompares;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == abort_at) begin
            reset = 1'b1;
            #1;
            check("abort_txout", txout, 0);
            check("abort_busy", busy, 0);
            check("abort_bitreq", bitreq, 0);
            @(negedge clk);
            reset = 1'b0;
            $display("frame m=%0d trext=%0d trcal=%0d reset at cycle %0d", fm, ftx, ftr, c);
            return;
         end
         if (miscompares == err0) begin
            check("busy", busy, 1);
            check("txout", txout, lv[c]);
            check("bitreq", bitreq, rq[c]);
         end
         if (bitreq) begin
            nreq++;
            if (k < nbits) begin txbit = dbits[k]; txlast = (k == nbits - 1); end
            k++;
         end else if (glitch) begin
            txbit = 1'($urandom); txlast = 1'($urandom);
         end else if (k < nbits) begin
            txbit = dbits[k]; txlast = (k == nbits - 1);
         end
         if (c == disturb_at) begin
            start = 1'b1; trcal = 10'($urandom); m = 2'($urandom); trext = 1'($urandom);
         end
      end
      @(negedge clk);
      start = 1'b0;
      check("end_busy", busy, 0);
      check("done_pulse", done, 1);
      check("end_txout", txout, 0);
      check("bitreq_count", nreq, nbits);
      @(negedge clk);
      check("done_clear", done, 0);
      $display("frame m=%0d trext=%0d trcal=%0d bits=%0d data=%04h busy_cycles=%0d bitreqs=%0d",
               fm, ftx, ftr, nbits, dbits, len, nreq);
   endtask

   initial begin
      start = 1'b0; trcal = 10'd160; m = 2'd0; trext = 1'b0; txbit = 1'b0; txlast = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txout", txout, 0);
      check("rst_bitreq", bitreq, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // FM0 single data-0, no pilot
      run_frame(2'd0, 1'b0, 10'd160, 16'h0000, 1, 1'b0, -1, -1);
      // FM0 pilot with HP clamped to 1
      run_frame(2'd0, 1'b1, 10'd10, 16'h0001, 1, 1'b0, -1, -1);
      // Miller M=4, data 1,0
      run_frame(2'd2, 1'b0, 10'd64, 16'h0001, 2, 1'b0, -1, -1);
      // Reset in the third preamble symbol, then a clean frame
      run_frame(2'd0, 1'b0, 10'd160, 16'h0000, 1, 1'b0, -1, 45);
      run_frame(2'd0, 1'b0, 10'd160, 16'h0000, 1, 1'b0, -1, -1);
      // start pulse and parameter changes mid-frame
      run_frame(2'd1, 1'b0, 10'd80, 16'h000B, 4, 1'b0, 100, -1);
      run_frame(2'd0, 1'b1, 10'd48, 16'h0006, 3, 1'b0, 70, -1);
      // Alternating data with txbit glitches outside bitreq cycles
      run_frame(2'd0, 1'b0, 10'd48, 16'h0055, 8, 1'b1, -1, -1);
      run_frame(2'd3, 1'b1, 10'd32, 16'h00AA, 8, 1'b1, -1, -1);
      // Randomized frames
      for (int i = 0; i < 6; i++) begin
         run_frame(2'($urandom_range(0, 3)), 1'($urandom), 10'($urandom_range(16, 160)),
                   16'($urandom), $urandom_range(1, 8), 1'($urandom), -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
